// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receiver for the single-wire serial link driven by the frame transmitter.
//   The line idles high. A frame is a start bit (0), DATA_W data bits sent
//   LSB first, an optional even-parity bit, then a stop bit (1). Each bit is
//   sampled at its midpoint. Received words are presented on a valid/ready
//   port, and framing errors and overruns are reported as 1-cycle pulses.
//
//   Optional feature macro: SERIAL_FRAME_RX_PARITY_EN
//     defined   : an even-parity bit follows the data; a mismatch is reported
//                 as frame_err when the stop bit is sampled
//     undefined : the stop bit follows the last data bit directly
//
//   Ports
//     clk        in   1       clock; all logic on posedge
//     rstn       in   1       synchronous active-low reset
//     rxd        in   1       serial line, asynchronous to clk, idles 1
//     out_data   out  DATA_W  received word, stable while out_valid=1
//     out_valid  out  1       word available, held until accepted
//     out_ready  in   1       consumer accepts on out_valid & out_ready
//     frame_err  out  1       pulse: bad stop bit or parity, frame dropped
//     overrun    out  1       pulse: good frame arrived while word still held
//     busy       out  1       receiver not in IDLE (0 during reset)
//
//   state     | meaning
//   WAIT_HIGH | wait for the line to be high before accepting a start bit
//   IDLE      | line high, waiting for a falling edge
//   START     | timing to the middle of the start bit
//   DATA      | sampling data bits at mid-bit
//   PARITY    | sampling the parity bit (parity build only)
//   STOP      | sampling the stop bit

module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                meta_q, rxs_q;
  logic [1:0]          flush_q;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_err_q, par_err_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q, frame_err_q, overrun_q;
  logic                stop_sample, good_frame;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    stop_sample = 1'b0;
    unique case (state_q)
      S_WAIT_HIGH: begin
        clk_cnt_d = '0;
        // The sync flops reset high whatever the line does; only trust rxs
        // once real line samples have flushed through both of them.
        if (rxs_q && flush_q[1]) state_d = S_IDLE;
      end
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        par_err_d = 1'b0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = (shift_q >> 1) | (DATA_W'(rxs_q) << (DATA_W - 1));
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_err_d = rxs_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d   = '0;
          stop_sample = 1'b1;
          // A bad frame leaves the line possibly still low; resync first.
          state_d     = (rxs_q && !par_err_q) ? S_IDLE : S_WAIT_HIGH;
        end
      end
      default: state_d = S_WAIT_HIGH;
    endcase
    good_frame = stop_sample & rxs_q & ~par_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q      <= 1'b1;
      rxs_q       <= 1'b1;
      flush_q     <= '0;
      state_q     <= S_WAIT_HIGH;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      meta_q      <= rxd;
      rxs_q       <= meta_q;
      flush_q     <= {flush_q[0], 1'b1};
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= stop_sample & ~good_frame;
      overrun_q   <= good_frame & out_valid_q & ~out_ready;
      // A word accepted in the same cycle frees the holding register.
      if (good_frame && (!out_valid_q || out_ready)) begin
        out_data_q  <= shift_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = rstn & (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;
  localparam int DATA_W = 8;
  localparam int CPB    = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int LAT = 3 + CPB / 2 + CPB * DATA_W + 2 * CPB;
`else
  localparam int LAT = 3 + CPB / 2 + CPB * DATA_W + CPB;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rxd = 1'b1;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, frame_err, overrun, busy;

  serial_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  int valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, valid_rise_cyc = -1;
  int last_start = 0;
  logic prev_valid = 1'b0;

  // Monitor: pops the expected word on every accepted transfer.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) valid_cycles++;
      if (out_valid && !prev_valid) valid_rise_cyc = cyc;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %h, required no word", out_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (out_data !== exp_word) begin
            errors++;
            $display("FAIL word_data: got %h, required %h", out_data, exp_word);
          end
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic [11:0] f;
    int n;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    f = {2'b00, stop, (^d) ^ bad_par, d, 1'b0};
    n = DATA_W + 3;
`else
    f = {bad_par, 1'b0, stop, d, 1'b0};
    n = DATA_W + 2;
`endif
    @(posedge clk);
    #1;
    last_start = cyc;
    for (int i = 0; i < n; i++) begin
      rxd = f[i];
      cycles(CPB);
    end
  endtask

  int v0, f0, o0;

  initial begin
    cycles(3);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycles(5);
    check("idle_busy", busy, 0);

    // 1: single word, consumer ready
    out_ready = 1'b1;
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    cycles(4);
    check("t1_latency", valid_rise_cyc, last_start + LAT);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: overrun while holding
    out_ready = 1'b0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1);
    cycles(2);
    send_frame(8'h81, 1'b0, 1'b1);
    cycles(4);
    check("t2_overrun_cnt", ovr_cnt - o0, 1);
    check("t2_frame_err_cnt", ferr_cnt - f0, 0);
    @(negedge clk);
    check("t2_held_valid", out_valid, 1);
    check("t2_held_data", out_data, 8'h3C);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t2_valid_dropped", out_valid, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: bad stop bit, line held low, then recovery
    v0 = valid_cycles; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    cycles(40);
    check("t3_frame_err_cnt", ferr_cnt - f0, 1);
    check("t3_no_valid", valid_cycles - v0, 0);
    @(negedge clk);
    check("t3_wait_high_busy", busy, 1);
    @(posedge clk); #1;
    rxd = 1'b1;
    cycles(6);
    check("t3_idle_busy", busy, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b1);
    cycles(4);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: short low glitch
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    cycles(4);
    rxd = 1'b1;
    cycles(2);
    @(negedge clk);
    check("t4_busy_in_start", busy, 1);
    cycles(20);
    check("t4_busy_after", busy, 0);
    check("t4_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check("t4_no_valid", valid_cycles - v0, 0);

    // 5: reset mid-frame with line low
    rxd = 1'b0;
    cycles(CPB);
    rxd = 1'b1;
    cycles(3 * CPB + CPB / 2);
    rxd = 1'b0;
    rstn = 1'b0;
    cycles(2);
    @(negedge clk);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_data", out_data, 0);
    check("t5_rst_frame_err", frame_err, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    v0 = valid_cycles; f0 = ferr_cnt;
    cycles(300);
    check("t5_stuck_low_busy", busy, 1);
    check("t5_stuck_low_no_err", ferr_cnt - f0, 0);
    check("t5_stuck_low_no_valid", valid_cycles - v0, 0);
    rxd = 1'b1;
    cycles(6);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b0, 1'b1);
    cycles(4);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 6: parity good then bad
    v0 = valid_cycles; f0 = ferr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    cycles(2);
    send_frame(8'h07, 1'b1, 1'b1);
    cycles(4);
    check("t6_frame_err_cnt", ferr_cnt - f0, 1);
    check("t6_valid_cycles", valid_cycles - v0, 1);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
